// File: rtl/tx_timer_pkg.sv
// Shared types and constants for the I2C slave transmit bit sequencer.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        ACK_WAIT,
        ACK_HOLD,
        DONE
    } tx_state_t;

    localparam int                   BYTE_BITS     = 8;
    localparam logic                 SDA_RELEASE   = 1'b1;
    localparam logic [BYTE_BITS-1:0] UNDERRUN_BYTE = 8'hFF;

endpackage

// File: rtl/tx_timer_if.sv
// Transmit FIFO handshake between the data FIFO (master) and tx_timer (slave).
interface tx_timer_if;
    import tx_pkg::*;

    logic [BYTE_BITS-1:0] tx_data;
    logic                 tx_data_valid;
    logic                 data_taken;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  data_taken
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output data_taken
    );

endinterface

// File: rtl/tx_timer_flex_counter.sv
// Up-counter with synchronous clear; wraps to zero after ROLLOVER_VAL.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int ROLLOVER_VAL = 9
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] ROLL = NUM_CNT_BITS'(ROLLOVER_VAL);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= (count_out == ROLL) ? '0 : count_out + 1'b1;
        end
    end

endmodule

// File: rtl/tx_timer.sv
// Transmit-side bit sequencer for the I2C slave during master-read transfers.
// Optional bus-arbitration check is enabled with the TX_ARB_CHECK_EN macro.
module tx_timer
    import tx_pkg::*;
#(
    parameter int CNT_BITS = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       sda_in,
    input  logic       tx_enable,
    tx_timer_if.slave  fifo,
    output logic       sda_out,
    output logic       byte_sent,
    output logic       ack_received,
    output logic       nack_received,
    output logic       underrun,
`ifdef TX_ARB_CHECK_EN
    output logic       bit_error,
`endif
    output logic       busy
);

    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(BYTE_BITS);
    localparam logic [CNT_BITS-1:0] PRE_LAST = CNT_BITS'(BYTE_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [BYTE_BITS-1:0] shift_reg;
    logic [BYTE_BITS-1:0] shift_next;
    logic [CNT_BITS-1:0]  count;
    logic                 sda_next;
    logic                 taken_next;
    logic                 sent_next;
    logic                 ack_next;
    logic                 nack_next;
    logic                 underrun_next;
`ifdef TX_ARB_CHECK_EN
    logic                 bit_error_next;
`endif

    logic abort;
    logic fall_valid;
    logic load;
    logic cnt_up;
    logic clear;

    // A falling pulse coincident with a rising pulse is treated as noise.
    assign abort      = start_found | stop_found;
    assign fall_valid = falling_edge_found & ~rising_edge_found;
    assign load       = ~abort & fall_valid &
                        (((state == IDLE) & tx_enable) | (state == ACK_HOLD));
    assign cnt_up     = rising_edge_found & (state == SEND);
    assign clear      = load | abort;

    flex_counter #(CNT_BITS, BYTE_BITS + 1) bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (cnt_up),
        .count_out    (count)
    );

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        sda_next      = sda_out;
        taken_next    = 1'b0;
        sent_next     = 1'b0;
        ack_next      = 1'b0;
        nack_next     = 1'b0;
        underrun_next = 1'b0;
`ifdef TX_ARB_CHECK_EN
        bit_error_next = 1'b0;
`endif

        if (abort) begin
            state_next = IDLE;
            sda_next   = SDA_RELEASE;
        end else if (load) begin
            state_next = SEND;
            if (fifo.tx_data_valid) begin
                shift_next = fifo.tx_data;
                taken_next = 1'b1;
            end else begin
                shift_next    = UNDERRUN_BYTE;
                underrun_next = 1'b1;
            end
            sda_next = shift_next[BYTE_BITS-1];
        end else begin
            case (state)
                SEND: begin
                    if (rising_edge_found) begin
`ifdef TX_ARB_CHECK_EN
                        // Released line read back low: another transmitter owns the bus.
                        if ((sda_out == SDA_RELEASE) && !sda_in) begin
                            bit_error_next = 1'b1;
                            sda_next       = SDA_RELEASE;
                            state_next     = DONE;
                        end else if (count == PRE_LAST) begin
                            sent_next = 1'b1;
                        end
`else
                        if (count == PRE_LAST) begin
                            sent_next = 1'b1;
                        end
`endif
                    end else if (falling_edge_found) begin
                        if (count < LAST_BIT) begin
                            shift_next = {shift_reg[BYTE_BITS-2:0], SDA_RELEASE};
                            sda_next   = shift_reg[BYTE_BITS-2];
                        end else begin
                            sda_next   = SDA_RELEASE;
                            state_next = ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (rising_edge_found) begin
                        if (sda_in) begin
                            nack_next  = 1'b1;
                            state_next = DONE;
                        end else begin
                            ack_next   = 1'b1;
                            state_next = ACK_HOLD;
                        end
                    end
                end
                ACK_HOLD: begin
                end
                IDLE, DONE: begin
                    sda_next = SDA_RELEASE;
                end
                default: begin
                    state_next = IDLE;
                    sda_next   = SDA_RELEASE;
                end
            endcase
        end
    end

    // Releasing SDA in reset keeps the bus free even if reset hits mid-bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            shift_reg       <= UNDERRUN_BYTE;
            sda_out         <= SDA_RELEASE;
            fifo.data_taken <= 1'b0;
            byte_sent       <= 1'b0;
            ack_received    <= 1'b0;
            nack_received   <= 1'b0;
            underrun        <= 1'b0;
            busy            <= 1'b0;
`ifdef TX_ARB_CHECK_EN
            bit_error       <= 1'b0;
`endif
        end else begin
            state           <= state_next;
            shift_reg       <= shift_next;
            sda_out         <= sda_next;
            fifo.data_taken <= taken_next;
            byte_sent       <= sent_next;
            ack_received    <= ack_next;
            nack_received   <= nack_next;
            underrun        <= underrun_next;
            busy            <= (state_next != IDLE);
`ifdef TX_ARB_CHECK_EN
            bit_error       <= bit_error_next;
`endif
        end
    end

endmodule

// File: tb/tb_tx_timer.sv
// Self-checking bench for tx_timer: vector table, directed corner cases, random transfers.
module tb_tx_timer;
    import tx_pkg::*;

    typedef logic [7:0] obs_t;

    typedef struct {
        logic r;
        logic f;
        logic sp;
        logic sdi;
        obs_t exp;
    } vec_t;

    localparam int P_IDLE = 0;
    localparam int P_SEND = 1;
    localparam int P_ACKW = 2;
    localparam int P_HOLD = 3;
    localparam int P_DONE = 4;

    logic clk = 1'b0;
    logic n_rst;
    logic rise, fall, start, stop, sda_in, tx_enable;
    logic sda_out, byte_sent, ack_received, nack_received, underrun, busy;
`ifdef TX_ARB_CHECK_EN
    logic bit_error;
`endif

    tx_timer_if fifo();

    always #5 clk = ~clk;

    tx_timer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rising_edge_found  (rise),
        .falling_edge_found (fall),
        .start_found        (start),
        .stop_found         (stop),
        .sda_in             (sda_in),
        .tx_enable          (tx_enable),
        .fifo               (fifo),
        .sda_out            (sda_out),
        .byte_sent          (byte_sent),
        .ack_received       (ack_received),
        .nack_received      (nack_received),
        .underrun           (underrun),
`ifdef TX_ARB_CHECK_EN
        .bit_error          (bit_error),
`endif
        .busy               (busy)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: transfer phase, rises seen, bits already shifted out.
    int         m_phase;
    int         m_rises;
    int         m_shifts;
    logic [7:0] m_byte;
    logic       m_sda;
    obs_t       m_exp;

    function automatic obs_t pack_dut();
        logic berr;
`ifdef TX_ARB_CHECK_EN
        berr = bit_error;
`else
        berr = 1'b0;
`endif
        return {sda_out, fifo.data_taken, byte_sent, ack_received,
                nack_received, underrun, busy, berr};
    endfunction

    task automatic check_output(input string nm, input obs_t exp);
        obs_t got;
        got = pack_dut();
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b required %b (sda,taken,sent,ack,nack,under,busy,berr)",
                     nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_rises  = 0;
        m_shifts = 0;
        m_byte   = 8'hFF;
        m_sda    = 1'b1;
        m_exp    = 8'h80;
    endtask

    task automatic model_step(input logic r, input logic f, input logic st, input logic sp,
                              input logic sdi, input logic en, input logic v, input logic [7:0] d);
        logic tk, sn, ak, nk, ur, be;
        logic cur_sda;
        tk = 0; sn = 0; ak = 0; nk = 0; ur = 0; be = 0;
        cur_sda = m_sda;
        if (st || sp) begin
            m_phase = P_IDLE;
        end else if (f && !r && ((m_phase == P_IDLE && en) || m_phase == P_HOLD)) begin
            m_byte   = v ? d : 8'hFF;
            tk       = v;
            ur       = !v;
            m_rises  = 0;
            m_shifts = 0;
            m_phase  = P_SEND;
        end else begin
            case (m_phase)
                P_SEND: begin
                    if (r) begin
`ifdef TX_ARB_CHECK_EN
                        if (cur_sda && !sdi) begin
                            be      = 1;
                            m_phase = P_DONE;
                        end else begin
                            m_rises++;
                            if (m_rises == 8) sn = 1;
                        end
`else
                        m_rises++;
                        if (m_rises == 8) sn = 1;
`endif
                    end else if (f) begin
                        if (m_rises < 8) m_shifts++;
                        else m_phase = P_ACKW;
                    end
                end
                P_ACKW: begin
                    if (r) begin
                        if (sdi) begin nk = 1; m_phase = P_DONE; end
                        else     begin ak = 1; m_phase = P_HOLD; end
                    end
                end
                default: ;
            endcase
        end
        m_sda = (m_phase == P_SEND && m_shifts < 8) ? m_byte[7 - m_shifts] : 1'b1;
        m_exp = {m_sda, tk, sn, ak, nk, ur, (m_phase != P_IDLE), be};
    endtask

    task automatic apply_stimulus(input string nm, input logic r, input logic f,
                                  input logic st, input logic sp, input logic sdi);
        rise   = r;
        fall   = f;
        start  = st;
        stop   = sp;
        sda_in = sdi;
        model_step(r, f, st, sp, sdi, tx_enable, fifo.tx_data_valid, fifo.tx_data);
        @(posedge clk);
        #1;
        check_output(nm, m_exp);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply_stimulus("idle", 0, 0, 0, 0, m_sda);
    endtask

    // Eight data SCL cycles; optionally a combined rise+fall pulse, or a STOP before a rise.
    task automatic data_bits(input int gap, input int both_at, input int abort_at,
                             output bit aborted);
        aborted = 0;
        for (int b = 0; b < 8; b++) begin
            idle_cycles(gap);
            if (b == abort_at) begin
                apply_stimulus("abort_stop", 0, 0, 0, 1, m_sda);
                aborted = 1;
                return;
            end
            apply_stimulus("data_rise", 1, (b == both_at), 0, 0, m_sda);
            idle_cycles(gap);
            apply_stimulus("data_fall", 0, 1, 0, 0, m_sda);
        end
    endtask

    task automatic ack_rise(input int gap, input logic lvl);
        idle_cycles(gap);
        apply_stimulus("ack_rise", 1, 0, 0, 0, lvl);
    endtask

    vec_t tbl[19];
    bit   ab;

    initial begin
        tbl[0]  = '{0, 1, 0, 1, 8'hC2};
        tbl[1]  = '{1, 0, 0, 1, 8'h82};
        tbl[2]  = '{0, 1, 0, 1, 8'h02};
        tbl[3]  = '{1, 0, 0, 0, 8'h02};
        tbl[4]  = '{0, 1, 0, 1, 8'h82};
        tbl[5]  = '{1, 0, 0, 1, 8'h82};
        tbl[6]  = '{0, 1, 0, 1, 8'h02};
        tbl[7]  = '{1, 0, 0, 0, 8'h02};
        tbl[8]  = '{0, 1, 0, 1, 8'h02};
        tbl[9]  = '{1, 0, 0, 0, 8'h02};
        tbl[10] = '{0, 1, 0, 1, 8'h82};
        tbl[11] = '{1, 0, 0, 1, 8'h82};
        tbl[12] = '{0, 1, 0, 1, 8'h02};
        tbl[13] = '{1, 0, 0, 0, 8'h02};
        tbl[14] = '{0, 1, 0, 1, 8'h82};
        tbl[15] = '{1, 0, 0, 1, 8'hA2};
        tbl[16] = '{0, 1, 0, 1, 8'h82};
        tbl[17] = '{1, 0, 0, 0, 8'h92};
        tbl[18] = '{0, 0, 1, 1, 8'h80};

        n_rst = 0; rise = 0; fall = 0; start = 0; stop = 0; sda_in = 1; tx_enable = 0;
        fifo.tx_data = 8'h00; fifo.tx_data_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 8'h80);
        n_rst = 1;

        // Byte A5 with master ACK, edges back to back.
        tx_enable = 1; fifo.tx_data = 8'hA5; fifo.tx_data_valid = 1;
        for (int i = 0; i < 19; i++) begin
            apply_stimulus("a5_model", tbl[i].r, tbl[i].f, 0, tbl[i].sp, tbl[i].sdi);
            check_output($sformatf("a5_row%0d", i), tbl[i].exp);
        end

        // Two bytes 3C then C3; ACK first, NACK second; one combined rise+fall pulse.
        apply_stimulus("start", 0, 0, 1, 0, 1);
        fifo.tx_data = 8'h3C;
        apply_stimulus("load_3c", 0, 1, 0, 0, 1);
        data_bits(1, 2, -1, ab);
        ack_rise(1, 1'b0);
        fifo.tx_data = 8'hC3;
        idle_cycles(1);
        apply_stimulus("load_c3", 0, 1, 0, 0, m_sda);
        check_output("load_c3_first", 8'hC2);
        data_bits(0, -1, -1, ab);
        ack_rise(0, 1'b1);
        idle_cycles(3);
        check_output("done_held", 8'h82);
        apply_stimulus("done_fall", 0, 1, 0, 0, 1);
        apply_stimulus("done_stop", 0, 0, 0, 1, 1);
        check_output("done_to_idle", 8'h80);

        // FIFO empty at load.
        fifo.tx_data = 8'h12; fifo.tx_data_valid = 0;
        apply_stimulus("load_empty", 0, 1, 0, 0, 1);
        check_output("underrun_pulse", 8'h86);
        data_bits(1, -1, -1, ab);
        ack_rise(1, 1'b1);
        apply_stimulus("stop", 0, 0, 0, 1, 1);

        // STOP after third rise of byte 00, then a fresh A5 transfer.
        fifo.tx_data = 8'h00; fifo.tx_data_valid = 1;
        apply_stimulus("load_00", 0, 1, 0, 0, 1);
        data_bits(1, -1, 3, ab);
        check_output("abort_idle", 8'h80);
        apply_stimulus("start", 0, 0, 1, 0, 1);
        fifo.tx_data = 8'hA5;
        apply_stimulus("reload_a5", 0, 1, 0, 0, 1);
        check_output("reload_bit7", 8'hC2);
        data_bits(2, -1, -1, ab);
        ack_rise(1, 1'b1);
        apply_stimulus("stop", 0, 0, 0, 1, 1);

        // Reset while SDA is pulled low.
        fifo.tx_data = 8'h00;
        apply_stimulus("load_00b", 0, 1, 0, 0, 1);
        apply_stimulus("hold_low", 0, 0, 0, 0, 1);
        check_output("sda_low_before_reset", 8'h02);
        rise = 0; fall = 0; start = 0; stop = 0;
        #2;
        n_rst = 0;
        #1;
        check_output("async_reset_release", 8'h80);
        @(posedge clk);
        #1;
        check_output("reset_held", 8'h80);
        n_rst = 1;
        model_reset();

`ifdef TX_ARB_CHECK_EN
        // Lost arbitration on the second rise of an all-ones byte.
        fifo.tx_data = 8'hFF;
        apply_stimulus("load_ff", 0, 1, 0, 0, 1);
        apply_stimulus("arb_rise1", 1, 0, 0, 0, 1);
        apply_stimulus("arb_fall1", 0, 1, 0, 0, 1);
        apply_stimulus("arb_rise2", 1, 0, 0, 0, 0);
        check_output("bit_error_pulse", 8'h83);
        idle_cycles(2);
        check_output("arb_done", 8'h82);
        apply_stimulus("stop", 0, 0, 0, 1, 1);
`endif

        // Random transfers against the reference model.
        for (int t = 0; t < 40; t++) begin
            int nb;
            int gap;
            nb  = $urandom_range(1, 3);
            gap = $urandom_range(0, 3);
            tx_enable = ($urandom_range(0, 7) != 0);
            apply_stimulus("rnd_start", 0, 0, 1, 0, 1);
            idle_cycles($urandom_range(0, 2));
            for (int b = 0; b < nb; b++) begin
                logic ackv;
                fifo.tx_data       = 8'($urandom);
                fifo.tx_data_valid = ($urandom_range(0, 9) != 0);
                apply_stimulus("rnd_load", 0, 1, 0, 0, m_sda);
                data_bits(gap, -1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1, ab);
                if (ab) break;
                ackv = (b == nb - 1) ? 1'b1 : ($urandom_range(0, 5) == 0);
                ack_rise(gap, ackv);
                if (ackv) break;
                idle_cycles(gap);
            end
            idle_cycles($urandom_range(0, 2));
            apply_stimulus("rnd_stop", 0, 0, 0, 1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_timer.md
Name: tx_timer

Overview:
- Transmit-side bit sequencer for the I2C slave during master-read transfers. It is the counterpart to the slave receive timer.
- On SCL falling edges it shifts a byte out MSB-first onto SDA. It then releases SDA for the ACK slot and samples the master's ACK/NACK on the 9th SCL rising edge.
- It sits between the SCL/SDA edge detectors and the transmit data FIFO. It drives the open-drain SDA output-enable logic.

Parameters:
- BYTE_BITS, 8, data bits per byte before the ACK slot.
- CNT_BITS, 4, width of the bit counter; must hold BYTE_BITS+1.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- rising_edge_found  input  1  single-cycle pulse: SCL rising edge detected.
- falling_edge_found  input  1  single-cycle pulse: SCL falling edge detected.
- start_found  input  1  single-cycle pulse: START or repeated START detected.
- stop_found  input  1  single-cycle pulse: STOP detected.
- sda_in  input  1  synchronized SDA line level.
- tx_enable  input  1  level: address matched with R/W=1; slave owns the data phase.
- tx_data  input  8  next byte from the transmit FIFO.
- tx_data_valid  input  1  FIFO non-empty.
- sda_out  output  1  1 = release SDA (high-Z), 0 = pull low.
- data_taken  output  1  single-cycle pulse: tx_data consumed (FIFO pop).
- byte_sent  output  1  single-cycle pulse: 8th data bit clocked by master.
- ack_received  output  1  single-cycle pulse: master ACKed (SDA=0 at 9th rise).
- nack_received  output  1  single-cycle pulse: master NACKed (SDA=1 at 9th rise).
- underrun  output  1  single-cycle pulse: load occurred with FIFO empty.
- busy  output  1  level: state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. n_rst is asynchronous and active-low.
- Reset values: state=IDLE, sda_out=1, shift register=8'hFF, bit count=0, all pulse outputs 0, busy=0.
- All outputs are registered. sda_out changes on the clk edge after the falling_edge_found pulse, i.e. 1-cycle latency.
- States and transitions:
  - IDLE: sda_out=1. If tx_enable=1 and falling_edge_found, go to LOAD action this cycle. That falling edge ends the address ACK slot.
  - LOAD (action, not a wait state):
    - If tx_data_valid: shift register <= tx_data and pulse data_taken.
    - Otherwise: shift register <= 8'hFF and pulse underrun.
    - sda_out <= loaded MSB, count <= 0, then go to SEND.
  - SEND:
    - Each rising_edge_found: count++.
    - When count reaches BYTE_BITS on a rise: pulse byte_sent in the same registered cycle.
    - Each falling_edge_found with count<BYTE_BITS: shift left, sda_out <= new MSB.
    - falling_edge_found with count==BYTE_BITS: sda_out <= 1, go to ACK_WAIT.
  - ACK_WAIT:
    - rising_edge_found, sda_in=0: pulse ack_received, go to ACK_HOLD.
    - rising_edge_found, sda_in=1: pulse nack_received, go to DONE.
  - ACK_HOLD: falling_edge_found performs the LOAD action for the next byte and returns to SEND.
  - DONE: sda_out=1. Wait for stop_found or start_found, then go to IDLE.
- Priority:
  - stop_found or start_found in any state forces IDLE, sda_out=1, count=0 next cycle. This overrides simultaneous edge pulses.
  - A simultaneous rising and falling pulse is illegal; the falling edge is ignored.
- tx_enable deassertion mid-byte is ignored. Only START/STOP or NACK ends the transfer.
- Counter wraps never occur: count is cleared on every LOAD and on abort.
- Reset asserted mid-byte: sda_out is released immediately (asynchronous), so the bus is never held low.

Optional Feature:
- Macro: TX_ARB_CHECK_EN.
- Defined: in SEND, on each rising_edge_found where sda_out=1 but sda_in=0, the block has lost the bus. It then:
  - pulses extra output bit_error (port exists only when the macro is defined),
  - forces sda_out=1,
  - goes to DONE.
- Undefined: no check and no bit_error port; sda_in is used only in ACK_WAIT.

Decomposition:
- Package tx_pkg holds:
  - typedef enum logic [2:0] {IDLE, SEND, ACK_WAIT, ACK_HOLD, DONE} tx_state_t,
  - localparam BYTE_BITS=8,
  - localparam SDA_RELEASE=1'b1,
  - localparam UNDERRUN_BYTE=8'hFF.
- Sub-module: the existing flex_counter (#(CNT_BITS, BYTE_BITS+1)) counts SCL rises.
  - cnt_up = rising_edge_found & (state==SEND).
  - clear = load | abort.
- Shift register and FSM stay in tx_timer.

Test Plan:
- Byte 8'hA5 valid, tx_enable=1, 9 SCL cycles, master ACK -> sda_out sequence 1,0,1,0,0,1,0,1 then 1. Expect data_taken once, byte_sent at 8th rise, ack_received at 9th rise.
- Two bytes 8'h3C then 8'hC3, master ACKs first and NACKs second -> second load on falling edge after ACK. Expect nack_received, state DONE, sda_out=1 until stop_found.
- FIFO empty at load (tx_data_valid=0) -> underrun pulse, 8'hFF shifted (sda_out held 1), no data_taken.
- stop_found after 3rd rise of byte 8'h00 -> sda_out=1 next cycle, busy=0, count reset. A following start/transfer starts from bit 7.
- n_rst asserted while sda_out=0 -> sda_out=1 asynchronously, all pulses 0.
- With TX_ARB_CHECK_EN: byte 8'hFF, force sda_in=0 at 2nd rise -> bit_error pulse, DONE, sda_out=1.
